// File: rtl/wave_playback_engine.sv
// wave_playback_engine: per audio tick, advances one fractional phase accumulator per oscillator,
// drives the integer phase as the BRAM read address, waits out the two-cycle read latency, then
// sums the enabled oscillator samples serially into one mix word.
// Optional feature: define WAVE_PLAYBACK_SATURATE_EN to clamp the mix to the sample range.
module wave_playback_engine #(
  parameter int unsigned NUM_OSCILLATORS = 4,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned WW_WIDTH        = 18,
  parameter int unsigned PHASE_FRAC      = 8,
  localparam int unsigned MIX_WIDTH      = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS)
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   sample_tick_in,
  input  logic [WW_WIDTH-1:0]                                    wave_width_in,
  input  logic                                                   reload_busy_in,
  input  logic [NUM_OSCILLATORS-1:0]                             osc_is_on_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH+PHASE_FRAC-1:0]    osc_inc_in,
  output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]               osc_index_out,
  input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]           osc_data_in,
  output logic [MIX_WIDTH-1:0]                                   mix_out,
  output logic                                                   mix_valid_out,
  output logic                                                   overrun_out
);

  localparam int unsigned PhaseW = WW_WIDTH + PHASE_FRAC;
  localparam int unsigned CntW   = $clog2(NUM_OSCILLATORS);
  localparam int unsigned ExtW   = MIX_WIDTH - SAMPLE_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StAdvance, StWait1, StWait2, StAccum, StOutput
  } state_e;

  state_e                                  state_q, state_d;
  logic [CntW-1:0]                         k_q, k_d;
  logic [MIX_WIDTH-1:0]                    acc_q, acc_d;
  logic [MIX_WIDTH-1:0]                    mix_q, mix_d;
  logic                                    overrun_q, overrun_d;
  logic [NUM_OSCILLATORS-1:0][PhaseW-1:0]  phase_q, phase_d;
  logic [NUM_OSCILLATORS-1:0][PhaseW-1:0]  phase_adv;

  // Final mix shaping applied when the accumulator is handed to the output.
  function automatic logic [MIX_WIDTH-1:0] finish_mix(input logic [MIX_WIDTH-1:0] a);
`ifdef WAVE_PLAYBACK_SATURATE_EN
    logic signed [MIX_WIDTH-1:0] sa, hi, lo;
    sa = $signed(a);
    hi = $signed({{(ExtW + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}});
    lo = $signed({{(ExtW + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}});
    if (sa > hi) begin
      return hi;
    end else if (sa < lo) begin
      return lo;
    end
    return a;
`else
    return a;
`endif
  endfunction

  // Candidate next phase per oscillator: add increment, wrap once, zero if still out of range.
  always_comb begin
    logic [PhaseW:0] sum;
    logic [PhaseW:0] lim;
    logic [PhaseW:0] wrapped;
    lim = {1'b0, wave_width_in, {PHASE_FRAC{1'b0}}};
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      sum     = {1'b0, phase_q[i]} + {1'b0, osc_inc_in[i]};
      wrapped = sum - lim;
      if (wave_width_in == '0 || !osc_is_on_in[i]) begin
        phase_adv[i] = '0;
      end else if (sum < lim) begin
        phase_adv[i] = sum[PhaseW-1:0];
      end else if (wrapped < lim) begin
        phase_adv[i] = wrapped[PhaseW-1:0];
      end else begin
        phase_adv[i] = '0;
      end
    end
  end

  // Next-state logic for the sequencer, phases, accumulator and mix register.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    mix_d     = mix_q;
    overrun_d = overrun_q;
    phase_d   = phase_q;
    if (sample_tick_in && state_q != StIdle) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (sample_tick_in) begin
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        phase_d = phase_adv;
        acc_d   = '0;
        k_d     = '0;
        state_d = StWait1;
      end
      StWait1: state_d = StWait2;
      StWait2: state_d = StAccum;
      StAccum: begin
        if (osc_is_on_in[k_q] && !reload_busy_in) begin
          acc_d = acc_q + {{ExtW{osc_data_in[k_q][SAMPLE_WIDTH-1]}}, osc_data_in[k_q]};
        end
        k_d = k_q + 1'b1;
        if (k_q == CntW'(NUM_OSCILLATORS - 1)) begin
          // Load the mix register here so it is already valid during OUTPUT.
          mix_d   = finish_mix(acc_d);
          state_d = StOutput;
        end
      end
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any tick in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      k_q       <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      overrun_q <= 1'b0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      mix_q     <= mix_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
    end
  end

  // Output decode: integer phase as BRAM address, strobe during OUTPUT.
  always_comb begin
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      osc_index_out[i] = phase_q[i][PhaseW-1:PHASE_FRAC];
    end
    mix_out       = mix_q;
    mix_valid_out = (state_q == StOutput);
    overrun_out   = overrun_q;
  end

endmodule

// File: tb/tb_wave_playback_engine.sv
// Directed bench for wave_playback_engine (N=4, 16-bit samples, 18-bit widths, 8 frac bits).
module tb_wave_playback_engine;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  sample_tick_in;
  logic [17:0]           wave_width_in;
  logic                  reload_busy_in;
  logic [3:0]            osc_is_on_in;
  logic [3:0][25:0]      osc_inc_in;
  logic [3:0][17:0]      osc_index_out;
  logic [3:0][15:0]      osc_data_in;
  logic [17:0]           mix_out;
  logic                  mix_valid_out;
  logic                  overrun_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  wave_playback_engine dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sample_tick_in(sample_tick_in),
    .wave_width_in (wave_width_in),
    .reload_busy_in(reload_busy_in),
    .osc_is_on_in  (osc_is_on_in),
    .osc_inc_in    (osc_inc_in),
    .osc_index_out (osc_index_out),
    .osc_data_in   (osc_data_in),
    .mix_out       (mix_out),
    .mix_valid_out (mix_valid_out),
    .overrun_out   (overrun_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // One tick, then 20 cycles of observation; optional second tick at cycle extra_at.
  task automatic run_tick(input int extra_at, output int lat, output int strobes);
    lat     = -1;
    strobes = 0;
    sample_tick_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      sample_tick_in = (c == extra_at);
      if (mix_valid_out) begin
        strobes++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  initial begin
    int lat;
    int strobes;
    int exp1 [9];
    int exp2 [6];
    logic [17:0] exp_pos;
    logic [17:0] exp_neg;

    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    wave_width_in  = 18'd8;
    reload_busy_in = 1'b0;
    osc_is_on_in   = 4'b0001;
    osc_inc_in     = '0;
    osc_data_in    = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    check_val("rst_index0", 32'(osc_index_out[0]), 32'd0);
    check_val("rst_mix", 32'(mix_out), 32'd0);
    check_val("rst_valid", 32'(mix_valid_out), 32'd0);
    check_val("rst_overrun", 32'(overrun_out), 32'd0);

    // Integer increment, wrap at 8.
    exp1 = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    osc_inc_in[0] = 26'h100;
    for (int t = 0; t < 9; t++) begin
      run_tick(0, lat, strobes);
      check_val($sformatf("t1_idx%0d", t), 32'(osc_index_out[0]), 32'(exp1[t]));
      check_val($sformatf("t1_lat%0d", t), 32'(lat), 32'd8);
      check_val($sformatf("t1_strobes%0d", t), 32'(strobes), 32'd1);
    end

    // Fractional increment 1.5.
    apply_reset();
    exp2 = '{1, 3, 4, 6, 7, 1};
    osc_inc_in[0] = 26'h180;
    for (int t = 0; t < 6; t++) begin
      run_tick(0, lat, strobes);
      check_val($sformatf("t2_idx%0d", t), 32'(osc_index_out[0]), 32'(exp2[t]));
    end

    // Full-scale sums.
`ifdef WAVE_PLAYBACK_SATURATE_EN
    exp_pos = 18'h07FFF;
    exp_neg = 18'h38000;
`else
    exp_pos = 18'h1FFFC;
    exp_neg = 18'h20000;
`endif
    apply_reset();
    osc_is_on_in = 4'b1111;
    osc_inc_in   = '0;
    osc_data_in  = {4{16'h7FFF}};
    run_tick(0, lat, strobes);
    check_val("t3_pos_mix", 32'(mix_out), 32'(exp_pos));
    osc_data_in = {4{16'h8000}};
    run_tick(0, lat, strobes);
    check_val("t3_neg_mix", 32'(mix_out), 32'(exp_neg));
    check_val("t3_no_overrun", 32'(overrun_out), 32'd0);

    // Tick while busy.
    run_tick(5, lat, strobes);
    check_val("t4_strobes", 32'(strobes), 32'd1);
    check_val("t4_lat", 32'(lat), 32'd8);
    check_val("t4_overrun", 32'(overrun_out), 32'd1);
    run_tick(0, lat, strobes);
    check_val("t4_next_strobes", 32'(strobes), 32'd1);
    check_val("t4_next_lat", 32'(lat), 32'd8);
    check_val("t4_overrun_held", 32'(overrun_out), 32'd1);

    // Reload muting and disabled oscillator.
    apply_reset();
    osc_is_on_in   = 4'b1111;
    osc_inc_in     = '0;
    osc_inc_in[0]  = 26'h100;
    osc_inc_in[1]  = 26'h100;
    osc_data_in    = {4{16'h1234}};
    reload_busy_in = 1'b1;
    run_tick(0, lat, strobes);
    check_val("t5_busy_mix", 32'(mix_out), 32'd0);
    check_val("t5_busy_strobes", 32'(strobes), 32'd1);
    check_val("t5_busy_idx", 32'(osc_index_out[0]), 32'd1);
    reload_busy_in = 1'b0;
    osc_data_in    = {16'hFFFE, 16'h0010, 16'h0100, 16'h0001};
    run_tick(0, lat, strobes);
    check_val("t5_all_on_mix", 32'(mix_out), 32'h10F);
    osc_is_on_in = 4'b1101;
    run_tick(0, lat, strobes);
    check_val("t5_osc1_off_mix", 32'(mix_out), 32'h00F);
    check_val("t5_osc1_off_idx", 32'(osc_index_out[1]), 32'd0);
    check_val("t5_osc0_idx", 32'(osc_index_out[0]), 32'd3);

    // Width shrink, then reset during ACCUM.
    apply_reset();
    wave_width_in = 18'd16;
    osc_is_on_in  = 4'b0001;
    osc_inc_in    = '0;
    osc_inc_in[0] = 26'h100;
    osc_data_in   = {4{16'h0001}};
    for (int t = 0; t < 10; t++) run_tick(0, lat, strobes);
    check_val("t6_idx10", 32'(osc_index_out[0]), 32'd10);
    check_val("t6_mix_pre", 32'(mix_out), 32'd1);
    wave_width_in = 18'd4;
    run_tick(0, lat, strobes);
    check_val("t6_shrink_idx", 32'(osc_index_out[0]), 32'd0);
    sample_tick_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      sample_tick_in = 1'b0;
    end
    check_val("t6_idx_before_rst", 32'(osc_index_out[0]), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("t6_rst_idx", 32'(osc_index_out[0]), 32'd0);
    check_val("t6_rst_mix", 32'(mix_out), 32'd0);
    check_val("t6_rst_valid", 32'(mix_valid_out), 32'd0);
    strobes = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_in);
      if (mix_valid_out) strobes++;
    end
    check_val("t6_no_strobe", 32'(strobes), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
